// File: rtl/pp_stage_skid.sv
// Generic pipeline-stage register with a one-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pp_stage_skid #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [CTRL_W-1:0] ctrlIn,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] dataOut,
    output logic [CTRL_W-1:0] ctrlOut,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stallCount
);

    // State bits are {skidValid, mainValid}; 2'b10 is never reached legally.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        BAD   = 2'b10,
        SKID  = 2'b11
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;

    logic mainValid;
    logic skidValid;
    logic inFire;
    logic outFire;

    assign mainValid = state[0];
    assign skidValid = state[1];

    // inReady comes straight off the skid flop: no path from outReady.
    assign inReady   = ~skidValid;
    assign outValid  = mainValid;
    assign dataOut   = mainData;
    assign ctrlOut   = mainValid ? mainCtrl : '0;
    assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

    assign inFire  = inValid & inReady;
    assign outFire = outValid & outReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            mainData <= '0;
            mainCtrl <= '0;
            skidData <= '0;
            skidCtrl <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            mainCtrl <= '0;
            skidCtrl <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (inFire) begin
                        state    <= FULL;
                        mainData <= dataIn;
                        mainCtrl <= ctrlIn;
                    end
                end
                FULL: begin
                    if (inFire && outFire) begin
                        mainData <= dataIn;
                        mainCtrl <= ctrlIn;
                    end else if (outFire) begin
                        state <= EMPTY;
                    end else if (inFire) begin
                        state    <= SKID;
                        skidData <= dataIn;
                        skidCtrl <= ctrlIn;
                    end
                end
                SKID: begin
                    if (outFire) begin
                        state    <= FULL;
                        mainData <= skidData;
                        mainCtrl <= skidCtrl;
                        skidCtrl <= '0;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    mainCtrl <= '0;
                    skidCtrl <= '0;
                end
            endcase
        end
    end

    // Flush deliberately leaves the counter alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
        end else if (outValid && !outReady && (stallCount != '1)) begin
            stallCount <= stallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_pp_stage_skid.sv
// Bench for pp_stage_skid: queue-based reference model plus
// directed literal checks and a randomised handshake run.
module tb_pp_stage_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [95:0] dataIn;
    logic [15:0] ctrlIn;

    logic        inReady,  inReady2;
    logic        outValid, outValid2;
    logic [95:0] dataOut,  dataOut2;
    logic [15:0] ctrlOut,  ctrlOut2;
    logic [1:0]  occupancy, occupancy2;
    logic [15:0] stallCount;
    logic [1:0]  stallCount2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [95:0] d;
        logic [15:0] c;
    } ent_t;

    ent_t q[$];
    int   mStall16;
    int   mStall2;

    always #5 clk = ~clk;

    pp_stage_skid #(.DATA_W(96), .CTRL_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .inValid(inValid), .inReady(inReady),
        .dataIn(dataIn), .ctrlIn(ctrlIn),
        .outValid(outValid), .outReady(outReady),
        .dataOut(dataOut), .ctrlOut(ctrlOut),
        .occupancy(occupancy), .stallCount(stallCount)
    );

    pp_stage_skid #(.DATA_W(96), .CTRL_W(16), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .inValid(inValid), .inReady(inReady2),
        .dataIn(dataIn), .ctrlIn(ctrlIn),
        .outValid(outValid2), .outReady(outReady),
        .dataOut(dataOut2), .ctrlOut(ctrlOut2),
        .occupancy(occupancy2), .stallCount(stallCount2)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic modelClear();
        q.delete();
        mStall16 = 0;
        mStall2  = 0;
    endtask

    task automatic compareModel();
        logic        expValid;
        logic [15:0] expCtrl;
        expValid = (q.size() > 0);
        expCtrl  = expValid ? q[0].c : 16'h0;
        chk("outValid",   outValid,   expValid);
        chk("inReady",    inReady,    q.size() < 2);
        chk("occupancy",  occupancy,  q.size());
        chk("ctrlOut",    ctrlOut,    expCtrl);
        if (expValid) chk("dataOut", dataOut, q[0].d);
        chk("stallCount", stallCount, mStall16);
        chk("outValid2",  outValid2,  expValid);
        chk("ctrlOut2",   ctrlOut2,   expCtrl);
        if (expValid) chk("dataOut2", dataOut2, q[0].d);
        chk("stallCount2", stallCount2, mStall2);
    endtask

    // Advance one clock edge, update the model from the pre-edge inputs.
    task automatic tick();
        bit   mIn;
        bit   mOut;
        ent_t e;
        mIn  = inValid && (q.size() < 2);
        mOut = (q.size() > 0) && outReady;
        e.d  = dataIn;
        e.c  = ctrlIn;
        if (q.size() > 0 && !outReady) begin
            if (mStall16 < 65535) mStall16++;
            if (mStall2 < 3) mStall2++;
        end
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (mOut) void'(q.pop_front());
            if (mIn) q.push_back(e);
        end
        compareModel();
    endtask

    task automatic drive(input logic v, input logic [95:0] d,
                         input logic [15:0] c);
        inValid = v;
        dataIn  = d;
        ctrlIn  = c;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        outReady = 1'b0;
        drive(1'b0, '0, '0);
        modelClear();
        #3;
        chk("rst_outValid",   outValid,   1'b0);
        chk("rst_dataOut",    dataOut,    96'h0);
        chk("rst_ctrlOut",    ctrlOut,    16'h0);
        chk("rst_occupancy",  occupancy,  2'd0);
        chk("rst_stallCount", stallCount, 16'h0);
        chk("rst_inReady",    inReady,    1'b1);
        #9 reset = 1'b0;

        // Pass-through
        outReady = 1'b1;
        drive(1'b1, 96'h4, 16'h0011);
        tick();
        chk("pass_4", dataOut, 96'h4);
        drive(1'b1, 96'h8, 16'h0022);
        tick();
        chk("pass_8", dataOut, 96'h8);
        drive(1'b1, 96'hC, 16'h0033);
        tick();
        chk("pass_C", dataOut, 96'hC);
        chk("pass_occ", occupancy, 2'd1);
        chk("pass_inReady", inReady, 1'b1);
        drive(1'b0, '0, '0);
        tick();

        // Skid fill and drain
        outReady = 1'b0;
        drive(1'b1, 96'hA, 16'h00A0);
        tick();
        drive(1'b1, 96'hB, 16'h00B0);
        tick();
        chk("skid_occ", occupancy, 2'd2);
        chk("skid_inReady", inReady, 1'b0);
        drive(1'b1, 96'hC, 16'h00C0);
        tick();
        chk("skid_head", dataOut, 96'hA);
        outReady = 1'b1;
        tick();
        chk("drain_B", dataOut, 96'hB);
        tick();
        chk("drain_C", dataOut, 96'hC);
        drive(1'b0, '0, '0);
        tick();
        chk("drain_empty", outValid, 1'b0);

        // Flush bubble
        outReady = 1'b0;
        drive(1'b1, 96'h1, 16'hFFFF);
        tick();
        drive(1'b1, 96'h2, 16'hFFFF);
        tick();
        chk("fl_occ_pre", occupancy, 2'd2);
        flush = 1'b1;
        drive(1'b1, 96'hD, 16'hFFFF);
        tick();
        chk("fl_outValid", outValid, 1'b0);
        chk("fl_ctrlOut",  ctrlOut,  16'h0000);
        chk("fl_occ",      occupancy, 2'd0);
        chk("fl_inReady",  inReady,  1'b1);
        flush = 1'b0;
        drive(1'b0, '0, '0);
        outReady = 1'b1;
        repeat (3) tick();

        // Stall counter from a clean reset
        #2 reset = 1'b1;
        modelClear();
        @(negedge clk) reset = 1'b0;
        outReady = 1'b0;
        drive(1'b1, 96'h5, 16'h0005);
        tick();
        drive(1'b0, '0, '0);
        repeat (5) tick();
        chk("stall5", stallCount, 16'd5);
        chk("stall5_w2", stallCount2, 2'd3);
        tick();
        chk("stall6", stallCount, 16'd6);
        chk("stall6_w2", stallCount2, 2'd3);

        // Async reset while holding two entries
        drive(1'b1, 96'h6, 16'h0006);
        tick();
        chk("ar_occ_pre", occupancy, 2'd2);
        #2 reset = 1'b1;
        #1;
        modelClear();
        chk("ar_outValid", outValid,   1'b0);
        chk("ar_occ",      occupancy,  2'd0);
        chk("ar_inReady",  inReady,    1'b1);
        chk("ar_stall",    stallCount, 16'h0);
        @(negedge clk) reset = 1'b0;
        outReady = 1'b1;
        drive(1'b1, 96'h77, 16'h0707);
        tick();
        chk("ar_first", dataOut, 96'h77);
        drive(1'b0, '0, '0);
        tick();

        // Random handshake
        for (int i = 0; i < 10000; i++) begin
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 63) == 0);
            dataIn   = {$urandom, $urandom, $urandom};
            ctrlIn   = 16'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
